pong_ball_engine: RTL and testbench

- Parametrised successor to the free-bouncing ball block: a frame-stepped ball engine for a two-paddle pong game.
- Adds generic position width, paddle collision with speed-up, miss detection with score pulses, and a serve state machine with a programmable delay.
- Sits between the video timing generator, which supplies `frame_tick`, and the sprite renderer and score counters.

---
 rtl/pong_ball_engine_if.sv | 25 ++
 rtl/pong_ball_engine.sv | 229 ++++++++++++++++++++++
 tb/tb_pong_ball_engine.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pong_ball_engine_if.sv
// rtl/pong_ball_engine_if.sv - frame/paddle inputs and ball/score outputs of the pong ball engine
interface pong_ball_engine_if #(
  parameter int POS_W = 9
);
  logic             frame_tick;
  logic             serve;
  logic [POS_W-1:0] paddle_l_vpos;
  logic [POS_W-1:0] paddle_r_vpos;
  logic [POS_W-1:0] ball_hpos;
  logic [POS_W-1:0] ball_vpos;
  logic             ball_active;
  logic             score_l_pulse;
  logic             score_r_pulse;
  logic [1:0]       state;

  modport master (
    output frame_tick, serve, paddle_l_vpos, paddle_r_vpos,
    input  ball_hpos, ball_vpos, ball_active, score_l_pulse, score_r_pulse, state
  );

  modport slave (
    input  frame_tick, serve, paddle_l_vpos, paddle_r_vpos,
    output ball_hpos, ball_vpos, ball_active, score_l_pulse, score_r_pulse, state
  );
endinterface

// File: rtl/pong_ball_engine.sv
// rtl/pong_ball_engine.sv - frame-stepped pong ball with paddle hits, misses and serve delay
// Optional spin on paddle hits is enabled by defining PONG_SPIN_EN.
module pong_ball_engine #(
  parameter int POS_W          = 9,
  parameter int DISPLAY_WIDTH  = 256,
  parameter int DISPLAY_HEIGHT = 240,
  parameter int BALL_SIZE      = 4,
  parameter int PADDLE_HEIGHT  = 32,
  parameter int PADDLE_WIDTH   = 4,
  parameter int PADDLE_X_LEFT  = 8,
  parameter int PADDLE_X_RIGHT = 244,
  parameter int INIT_SPEED     = 2,
  parameter int MAX_SPEED      = 6,
  parameter int SERVE_DELAY    = 60
) (
  input  logic                clk,
  input  logic                reset,
  pong_ball_engine_if.slave   bus
);

  // One spare bit so sums like hpos + size + speed can never wrap before compare
  localparam int W     = POS_W + 1;
  localparam int CNT_W = $clog2(SERVE_DELAY + 1);

  localparam logic [W-1:0]     C_BS      = W'(BALL_SIZE);
  localparam logic [W-1:0]     C_PH      = W'(PADDLE_HEIGHT);
  localparam logic [W-1:0]     C_LIM_Y   = W'(DISPLAY_HEIGHT - BALL_SIZE);
  localparam logic [W-1:0]     C_LIM_Y2  = W'(2 * (DISPLAY_HEIGHT - BALL_SIZE));
  localparam logic [W-1:0]     C_LIM_X   = W'(DISPLAY_WIDTH - BALL_SIZE);
  localparam logic [W-1:0]     C_EDGE_R  = W'(PADDLE_X_RIGHT);
  localparam logic [W-1:0]     C_EDGE_L  = W'(PADDLE_X_LEFT + PADDLE_WIDTH);
  localparam logic [POS_W-1:0] C_HCENTRE = POS_W'(DISPLAY_WIDTH / 2);
  localparam logic [POS_W-1:0] C_VCENTRE = POS_W'(DISPLAY_HEIGHT / 2);
  localparam logic [POS_W-1:0] C_STOP_R  = POS_W'(PADDLE_X_RIGHT - BALL_SIZE);
  localparam logic [POS_W-1:0] C_STOP_L  = POS_W'(PADDLE_X_LEFT + PADDLE_WIDTH);
  localparam logic [POS_W-1:0] C_WALL_R  = POS_W'(DISPLAY_WIDTH - BALL_SIZE);
  localparam logic [POS_W-1:0] C_INIT    = POS_W'(INIT_SPEED);
  localparam logic [POS_W-1:0] C_MAX     = POS_W'(MAX_SPEED);
  localparam logic [CNT_W-1:0] C_CNT_END = CNT_W'(SERVE_DELAY - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_SERVE_WAIT = 2'd1,
    S_PLAY       = 2'd2,
    S_MISS       = 2'd3
  } state_t;

  state_t           r_state;
  logic [POS_W-1:0] r_hpos;
  logic [POS_W-1:0] r_vpos;
  logic [POS_W-1:0] r_dx_mag;
  logic [POS_W-1:0] r_dy_mag;
  logic             r_dx_neg;
  logic             r_dy_neg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_active;
  logic             r_score_l;
  logic             r_score_r;

  logic [W-1:0]     w_hpos;
  logic [W-1:0]     w_vpos;
  logic [W-1:0]     w_dxm;
  logic [W-1:0]     w_dym;
  logic [W-1:0]     w_prv;
  logic [W-1:0]     w_plv;
  logic             w_ovl_r;
  logic             w_ovl_l;
  logic             w_hit_r;
  logic             w_hit_l;
  logic             w_miss_r;
  logic             w_miss_l;
  logic [POS_W-1:0] w_dx_up;
  logic [POS_W-1:0] w_vpos_nxt;
  logic             w_dy_neg_nxt;
  logic [POS_W-1:0] w_hit_dy_mag;
  logic             w_hit_dy_neg;

  assign w_hpos = W'(r_hpos);
  assign w_vpos = W'(r_vpos);
  assign w_dxm  = W'(r_dx_mag);
  assign w_dym  = W'(r_dy_mag);
  assign w_prv  = W'(bus.paddle_r_vpos);
  assign w_plv  = W'(bus.paddle_l_vpos);

  assign w_ovl_r  = (w_vpos + C_BS > w_prv) && (w_vpos < w_prv + C_PH);
  assign w_ovl_l  = (w_vpos + C_BS > w_plv) && (w_vpos < w_plv + C_PH);
  assign w_hit_r  = !r_dx_neg && (w_hpos + C_BS <= C_EDGE_R) &&
                    (w_hpos + C_BS + w_dxm >= C_EDGE_R) && w_ovl_r;
  assign w_hit_l  = r_dx_neg && (w_hpos >= C_EDGE_L) &&
                    (w_hpos <= C_EDGE_L + w_dxm) && w_ovl_l;
  assign w_miss_r = !r_dx_neg && (w_hpos + w_dxm >= C_LIM_X);
  assign w_miss_l = r_dx_neg && (w_hpos <= w_dxm);
  assign w_dx_up  = (r_dx_mag >= C_MAX) ? C_MAX : r_dx_mag + POS_W'(1);

  // Wall bounces reflect the overshoot back into the field
  always_comb begin
    w_vpos_nxt   = r_vpos;
    w_dy_neg_nxt = r_dy_neg;
    if (r_dy_neg) begin
      if (w_vpos < w_dym) begin
        w_vpos_nxt   = POS_W'(w_dym - w_vpos);
        w_dy_neg_nxt = 1'b0;
      end else begin
        w_vpos_nxt   = POS_W'(w_vpos - w_dym);
      end
    end else begin
      if (w_vpos + w_dym > C_LIM_Y) begin
        w_vpos_nxt   = POS_W'(C_LIM_Y2 - w_vpos - w_dym);
        w_dy_neg_nxt = 1'b1;
      end else begin
        w_vpos_nxt   = POS_W'(w_vpos + w_dym);
      end
    end
  end

`ifdef PONG_SPIN_EN
  logic [W-1:0] w_pv;
  logic [W-1:0] w_ctr;
  logic [W-1:0] w_off;

  assign w_pv  = r_dx_neg ? w_plv : w_prv;
  assign w_ctr = w_vpos + W'(BALL_SIZE / 2);
  assign w_off = w_ctr - w_pv;

  // Centre above the paddle top counts as the top third
  always_comb begin
    w_hit_dy_mag = POS_W'(1);
    w_hit_dy_neg = w_dy_neg_nxt;
    if ((w_ctr < w_pv) || (w_off < W'(PADDLE_HEIGHT / 3))) begin
      w_hit_dy_mag = POS_W'(2);
      w_hit_dy_neg = 1'b1;
    end else if (w_off >= W'(2 * PADDLE_HEIGHT / 3)) begin
      w_hit_dy_mag = POS_W'(2);
      w_hit_dy_neg = 1'b0;
    end
  end
`else
  assign w_hit_dy_mag = r_dy_mag;
  assign w_hit_dy_neg = w_dy_neg_nxt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_hpos    <= C_HCENTRE;
      r_vpos    <= C_VCENTRE;
      r_dx_mag  <= C_INIT;
      r_dy_mag  <= C_INIT;
      r_dx_neg  <= 1'b0;
      r_dy_neg  <= 1'b1;
      r_cnt     <= '0;
      r_active  <= 1'b0;
      r_score_l <= 1'b0;
      r_score_r <= 1'b0;
    end else begin
      r_score_l <= 1'b0;
      r_score_r <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.serve) begin
            r_state  <= S_SERVE_WAIT;
            r_cnt    <= '0;
            r_active <= 1'b1;
          end
        end
        S_SERVE_WAIT: begin
          r_hpos   <= C_HCENTRE;
          r_vpos   <= C_VCENTRE;
          r_active <= 1'b1;
          if (bus.frame_tick) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == C_CNT_END) begin
              r_state <= S_PLAY;
            end
          end
        end
        S_PLAY: begin
          if (bus.frame_tick) begin
            r_vpos   <= w_vpos_nxt;
            r_dy_neg <= w_dy_neg_nxt;
            if (w_hit_r || w_hit_l) begin
              r_hpos   <= w_hit_r ? C_STOP_R : C_STOP_L;
              r_dx_neg <= w_hit_r;
              r_dx_mag <= w_dx_up;
              r_dy_mag <= w_hit_dy_mag;
              r_dy_neg <= w_hit_dy_neg;
            end else if (w_miss_r) begin
              r_hpos    <= C_WALL_R;
              r_score_l <= 1'b1;
              r_active  <= 1'b0;
              r_state   <= S_MISS;
            end else if (w_miss_l) begin
              r_hpos    <= '0;
              r_score_r <= 1'b1;
              r_active  <= 1'b0;
              r_state   <= S_MISS;
            end else if (r_dx_neg) begin
              r_hpos <= r_hpos - r_dx_mag;
            end else begin
              r_hpos <= r_hpos + r_dx_mag;
            end
          end
        end
        S_MISS: begin
          // Relaunch back across the side the ball just left, i.e. toward the scorer
          if (bus.frame_tick) begin
            r_hpos   <= C_HCENTRE;
            r_vpos   <= C_VCENTRE;
            r_dx_mag <= C_INIT;
            r_dy_mag <= C_INIT;
            r_dx_neg <= ~r_dx_neg;
            r_cnt    <= '0;
            r_active <= 1'b1;
            r_state  <= S_SERVE_WAIT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ball_hpos     = r_hpos;
  assign bus.ball_vpos     = r_vpos;
  assign bus.ball_active   = r_active;
  assign bus.score_l_pulse = r_score_l;
  assign bus.score_r_pulse = r_score_r;
  assign bus.state         = r_state;

endmodule

// File: tb/tb_pong_ball_engine.sv
// tb/tb_pong_ball_engine.sv - directed self-checking bench for pong_ball_engine
module tb_pong_ball_engine;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pong_ball_engine_if #(.POS_W(9)) bus ();

  pong_ball_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_pos(input string tag, input int h, input int v);
    chk({tag, "_h"}, int'(bus.ball_hpos), h);
    chk({tag, "_v"}, int'(bus.ball_vpos), v);
  endtask

  initial begin
    bus.frame_tick    = 1'b0;
    bus.serve         = 1'b0;
    bus.paddle_l_vpos = 9'd0;
    bus.paddle_r_vpos = 9'd0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk_pos("rst", 128, 120);
    chk("rst_state", int'(bus.state), 0);
    chk("rst_active", int'(bus.ball_active), 0);
    chk("rst_sl", int'(bus.score_l_pulse), 0);
    chk("rst_sr", int'(bus.score_r_pulse), 0);
    ticks(10);
    chk_pos("idle_ticks", 128, 120);
    chk("idle_state", int'(bus.state), 0);

    // Run 1: right paddle at top, ball hits it
    bus.serve = 1'b1;
    @(negedge clk);
    bus.serve = 1'b0;
    chk("sw_state", int'(bus.state), 1);
    chk("sw_active", int'(bus.ball_active), 1);
    ticks(59);
    chk("sw59_state", int'(bus.state), 1);
    chk_pos("sw59", 128, 120);
    tick();
    chk("sw60_state", int'(bus.state), 2);
    chk_pos("sw60", 128, 120);
    tick();
    chk_pos("play1", 130, 118);
    ticks(54);
    chk_pos("play55", 238, 10);
    tick();
    chk_pos("hit56", 240, 8);
    chk("hit56_sl", int'(bus.score_l_pulse), 0);
    tick();
    chk_pos("hit57_dx3", 237, 6);

    // Reset mid-play with a coincident serve
    reset = 1'b1;
    bus.serve = 1'b1;
    @(negedge clk);
    chk_pos("mid_rst", 128, 120);
    chk("mid_rst_state", int'(bus.state), 0);
    chk("mid_rst_active", int'(bus.ball_active), 0);
    chk("mid_rst_sl", int'(bus.score_l_pulse), 0);
    reset = 1'b0;
    bus.serve = 1'b0;
    @(negedge clk);
    chk("mid_rst_serve_ign", int'(bus.state), 0);

    // Run 2: right paddle clear (miss), left paddle low (hit)
    bus.paddle_r_vpos = 9'd200;
    bus.paddle_l_vpos = 9'd220;
    bus.serve = 1'b1;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.serve = 1'b0;
    bus.frame_tick = 1'b0;
    chk("r2_sw_state", int'(bus.state), 1);
    ticks(59);
    chk("r2_sw59_state", int'(bus.state), 1);
    tick();
    chk("r2_sw60_state", int'(bus.state), 2);
    ticks(55);
    chk_pos("r2_play55", 238, 10);
    tick();
    chk_pos("r2_nohit56", 240, 8);
    chk("r2_nohit56_sl", int'(bus.score_l_pulse), 0);
    ticks(4);
    chk_pos("r2_top60", 248, 0);
    tick();
    chk_pos("r2_top61", 250, 2);
    tick();
    chk_pos("r2_miss62", 252, 4);
    chk("r2_miss_sl", int'(bus.score_l_pulse), 1);
    chk("r2_miss_sr", int'(bus.score_r_pulse), 0);
    chk("r2_miss_state", int'(bus.state), 3);
    chk("r2_miss_active", int'(bus.ball_active), 0);
    @(negedge clk);
    chk("r2_sl_width", int'(bus.score_l_pulse), 0);
    tick();
    chk_pos("r2_recentre", 128, 120);
    chk("r2_recentre_state", int'(bus.state), 1);
    chk("r2_recentre_active", int'(bus.ball_active), 1);
    ticks(59);
    chk("r2_sw2_59_state", int'(bus.state), 1);
    tick();
    chk("r2_sw2_60_state", int'(bus.state), 2);
    tick();
    chk_pos("r2_serve_dx_m2", 126, 122);
    ticks(56);
    chk_pos("r2_play57", 14, 234);
    tick();
    chk_pos("r2_lhit58", 12, 236);
    chk("r2_lhit58_sr", int'(bus.score_r_pulse), 0);
    tick();
    chk_pos("r2_bot59", 15, 234);
    chk("r2_final_state", int'(bus.state), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
